cache_bus_responder: RTL and testbench

Simulation and bring-up responder for the CPU's cache request interface (`addr`/`re`/`we`/`din` in, `dout`/`stall` out). It answers the requests a `Riscv150` core issues on its dcache or icache port. Accesses hit or miss against a single-line tag, and a miss stalls for a programmable number of cycles. Benches use it to exercise the CPU's stall handling without the DDR2 memory model. It is backed by an internal word array and keeps hit/miss counters for bench checking.

---
 rtl/cache_bus_responder.sv | 146 ++++++++++++++
 tb/tb_cache_bus_responder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cache_bus_responder.sv
// ---------------------------------------------------------------------------
// cache_bus_responder
//   Bring-up stand-in for the CPU cache request port. One tag covers a single
//   line; a hit is served on the sampling edge, a miss stalls for
//   MISS_LATENCY cycles and then performs the held access. Data lives in an
//   internal word array (not reset). Hit/miss counters saturate.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   async active-low reset
//   addr  [31:0] in  byte address ([1:0] ignored, index wraps/aliases)
//   re          in   read request
//   we    [3:0] in   byte write enables
//   din  [31:0] in   write data
//   dout [31:0] out  registered read data (pre-write word)
//   stall       out  registered; high while a miss is outstanding
//   hit_count   out  accepted hits (saturating)
//   miss_count  out  accepted misses (saturating)
// ---------------------------------------------------------------------------
module cache_bus_responder #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int LINE_WORDS   = 4,
    parameter int MISS_LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        stall,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 30 - OFF_W;
    localparam int CNT_W = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

    typedef enum logic {IDLE, MISS} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               tag_vld_q, tag_vld_d;
    logic [31:0]        dout_q, dout_d;
    logic               stall_q, stall_d;
    logic [31:0]        hit_q, hit_d;
    logic [31:0]        miss_q, miss_d;
    logic               do_access;

    logic [31:0] mem [DEPTH_WORDS];

    logic             req;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] idx;

    assign req     = re | (|we);
    assign req_tag = addr[31:2+OFF_W];
    assign idx     = addr[IDX_W+1:2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tag_d     = tag_q;
        tag_vld_d = tag_vld_q;
        dout_d    = dout_q;
        stall_d   = stall_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        do_access = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (tag_vld_q && (tag_q == req_tag)) begin
                        do_access = 1'b1;
                        if (hit_q != '1) hit_d = hit_q + 32'd1;
                    end else begin
                        state_d = MISS;
                        cnt_d   = CNT_W'(MISS_LATENCY - 1);
                        stall_d = 1'b1;
                        if (miss_q != '1) miss_d = miss_q + 32'd1;
                    end
                end
            end
            MISS: begin
                // Inputs are held by the initiator, so the access on the
                // final edge uses the live addr/we/din.
                if (cnt_q == '0) begin
                    do_access = 1'b1;
                    tag_d     = req_tag;
                    tag_vld_d = 1'b1;
                    stall_d   = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Read-before-write: dout returns the word as it was before this edge.
        if (do_access) dout_d = mem[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tag_q     <= '0;
            tag_vld_q <= 1'b0;
            dout_q    <= '0;
            stall_q   <= 1'b0;
            hit_q     <= '0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            tag_vld_q <= tag_vld_d;
            dout_q    <= dout_d;
            stall_q   <= stall_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
        end
    end

    // Array is never reset. The rst_n gate keeps a pending miss from writing
    // on an edge that coincides with reset being held.
    always_ff @(posedge clk) begin
        if (do_access && rst_n) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mem[idx][8*b +: 8] <= din[8*b +: 8];
            end
        end
    end

    assign dout       = dout_q;
    assign stall      = stall_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_bus_responder.sv
// Bench: three responders (MISS_LATENCY 8, 1, 3) share clock and reset.
// A driver issues directed requests and pushes the expected response; a
// monitor pops and compares whenever an access completes (stall low on the
// negedge following an edge where a request was presented).
module tb_cache_bus_responder;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a [NI];
    logic        r [NI];
    logic [3:0]  w [NI];
    logic [31:0] d [NI];
    logic [31:0] q [NI];
    logic        s [NI];
    logic [31:0] hc [NI];
    logic [31:0] mc [NI];
    logic        seen [NI];
    int          run [NI];

    typedef struct {
        string       name;
        int          inst;
        int          stall_cyc;
        bit          chk_dout;
        logic [31:0] dout;
        logic [31:0] hit;
        logic [31:0] miss;
    } exp_t;

    exp_t exp_q [$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cache_bus_responder #(.DEPTH_WORDS(1024), .LINE_WORDS(4), .MISS_LATENCY(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .addr(a[0]), .re(r[0]), .we(w[0]), .din(d[0]),
        .dout(q[0]), .stall(s[0]), .hit_count(hc[0]), .miss_count(mc[0]));
    cache_bus_responder #(.DEPTH_WORDS(1024), .LINE_WORDS(4), .MISS_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .addr(a[1]), .re(r[1]), .we(w[1]), .din(d[1]),
        .dout(q[1]), .stall(s[1]), .hit_count(hc[1]), .miss_count(mc[1]));
    cache_bus_responder #(.DEPTH_WORDS(1024), .LINE_WORDS(4), .MISS_LATENCY(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .addr(a[2]), .re(r[2]), .we(w[2]), .din(d[2]),
        .dout(q[2]), .stall(s[2]), .hit_count(hc[2]), .miss_count(mc[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Remember whether a request was presented at each rising edge.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) seen[k] <= (r[k] | (|w[k])) & rst_n;
    end

    // Monitor
    always begin
        @(negedge clk or negedge rst_n);
        #1;
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("rst_stall%0d", k), {31'd0, s[k]}, 32'd0);
                chk($sformatf("rst_dout%0d", k), q[k], 32'd0);
                chk($sformatf("rst_hit%0d", k), hc[k], 32'd0);
                chk($sformatf("rst_miss%0d", k), mc[k], 32'd0);
                run[k] = 0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (s[k]) begin
                    run[k]++;
                end else if (seen[k]) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_resp inst%0d: got dout %h expected no response", k, q[k]);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk({e.name, "_inst"}, k, e.inst);
                        chk({e.name, "_stall_cycles"}, run[k], e.stall_cyc);
                        if (e.chk_dout) chk({e.name, "_dout"}, q[k], e.dout);
                        chk({e.name, "_hits"}, hc[k], e.hit);
                        chk({e.name, "_misses"}, mc[k], e.miss);
                    end
                    run[k] = 0;
                end
            end
        end
    end

    // Present a request at the current negedge, hold it until stall is low
    // after the sampling edge, then drop it.
    task automatic issue(input int k, input string nm, input logic [31:0] ad, input logic re_v,
                         input logic [3:0] we_v, input logic [31:0] din_v, input int stc,
                         input bit cd, input logic [31:0] ed, input logic [31:0] eh,
                         input logic [31:0] em);
        exp_t e;
        int n;
        e.name = nm; e.inst = k; e.stall_cyc = stc; e.chk_dout = cd;
        e.dout = ed; e.hit = eh; e.miss = em;
        exp_q.push_back(e);
        a[k] = ad; r[k] = re_v; w[k] = we_v; d[k] = din_v;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (s[k] && n < 40);
        if (n >= 40) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: stall still %0d after %0d cycles, required 0", nm, s[k], n);
        end
        r[k] = 1'b0; w[k] = 4'h0;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            a[k] = '0; r[k] = 1'b0; w[k] = '0; d[k] = '0; run[k] = 0;
        end
        // Reset held 5 cycles with a read pending on the main responder.
        r[0] = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        issue(0, "rst_first_miss", 32'h0,    1'b1, 4'h0, 32'h0,        8, 0, 32'h0,        0, 1);
        issue(0, "wr_miss",        32'h100,  1'b0, 4'hF, 32'hDEADBEEF, 8, 0, 32'h0,        0, 2);
        issue(0, "rd_hit_104",     32'h104,  1'b1, 4'h0, 32'h0,        0, 0, 32'h0,        1, 2);
        issue(0, "rd_hit_100",     32'h100,  1'b1, 4'h0, 32'h0,        0, 1, 32'hDEADBEEF, 2, 2);
        issue(0, "rmw_byte1",      32'h100,  1'b1, 4'h2, 32'h0000AA00, 0, 1, 32'hDEADBEEF, 3, 2);
        issue(0, "rd_after_rmw",   32'h100,  1'b1, 4'h0, 32'h0,        0, 1, 32'hDEADAAEF, 4, 2);
        issue(0, "rd_next_line",   32'h110,  1'b1, 4'h0, 32'h0,        8, 0, 32'h0,        4, 3);
        issue(0, "rd_alias",       32'h1100, 1'b1, 4'h0, 32'h0,        8, 1, 32'hDEADAAEF, 4, 4);
        issue(0, "wr_prime_200",   32'h200,  1'b0, 4'hF, 32'h0BADF00D, 8, 0, 32'h0,        4, 5);
        issue(0, "rd_other_line",  32'h300,  1'b1, 4'h0, 32'h0,        8, 0, 32'h0,        4, 6);
        // Write miss killed by reset in its third stall cycle.
        a[0] = 32'h200; w[0] = 4'hF; d[0] = 32'h12345678;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        w[0] = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(0, "rd_after_rst",   32'h200,  1'b1, 4'h0, 32'h0,        8, 1, 32'h0BADF00D, 0, 1);
        // Latency variants: prime a word, then read it through an aliasing
        // address so the read misses and returns the primed data.
        issue(1, "lat1_wr",        32'h40,   1'b0, 4'hF, 32'hA5A50001, 1, 0, 32'h0,        0, 1);
        issue(1, "lat1_rd",        32'h1040, 1'b1, 4'h0, 32'h0,        1, 1, 32'hA5A50001, 0, 2);
        issue(2, "lat3_wr",        32'h40,   1'b0, 4'hF, 32'hA5A50003, 3, 0, 32'h0,        0, 1);
        issue(2, "lat3_rd",        32'h1040, 1'b1, 4'h0, 32'h0,        3, 1, 32'hA5A50003, 0, 2);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
